// File: rtl/dcpu_bus_arbiter.sv
// Two-master round-robin arbiter for the dcpu memory bus. The grant is held while the owner keeps cyc high.
// Transfers the slave never acknowledges are aborted with a one-cycle error pulse.
module dcpu_bus_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_m0_cyc,
    input  logic [3:0]    i_m0_stb,
    input  logic          i_m0_we,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_dat,
    output logic          o_m0_ack,
    output logic          o_m0_err,
    output logic [DW-1:0] o_m0_dat,
    input  logic          i_m1_cyc,
    input  logic [3:0]    i_m1_stb,
    input  logic          i_m1_we,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_dat,
    output logic          o_m1_ack,
    output logic          o_m1_err,
    output logic [DW-1:0] o_m1_dat,
    output logic          o_cyc,
    output logic [3:0]    o_stb,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_dat,
    input  logic          i_ack,
    input  logic [DW-1:0] i_dat,
    output logic [1:0]    o_grant
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       abort_q, abort_d;
    logic       own0, own1;
    logic [3:0] own_stb;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    // Both requesting from IDLE: the master that did not own the bus last wins.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) state_d = last_q ? GRANT0 : GRANT1;
                else if (i_m0_cyc)        state_d = GRANT0;
                else if (i_m1_cyc)        state_d = GRANT1;
            end
            GRANT0:  if (!i_m0_cyc) state_d = IDLE;
            GRANT1:  if (!i_m1_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == IDLE && state_d == GRANT0) last_d = 1'b0;
        if (state_q == IDLE && state_d == GRANT1) last_d = 1'b1;
    end

    // Ownership is masked while reset is held so nothing is forwarded during the reset cycle.
    assign own0    = (state_q == GRANT0) && !i_reset;
    assign own1    = (state_q == GRANT1) && !i_reset;
    assign own_stb = own0 ? i_m0_stb : (own1 ? i_m1_stb : 4'd0);

    // The abort flag marks the cycle after TIMEOUT stalled stb cycles.
    always_comb begin
        cnt_d   = cnt_q + 8'd1;
        abort_d = 1'b0;
        if (!(own0 || own1) || i_ack || own_stb == 4'd0 || abort_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == TO_LAST) begin
            abort_d = 1'b1;
        end
    end

    always_comb begin
        o_cyc  = 1'b0;
        o_we   = 1'b0;
        o_addr = '0;
        o_dat  = '0;
        if (own0) begin
            o_cyc  = i_m0_cyc;
            o_we   = i_m0_we;
            o_addr = i_m0_addr;
            o_dat  = i_m0_dat;
        end else if (own1) begin
            o_cyc  = i_m1_cyc;
            o_we   = i_m1_we;
            o_addr = i_m1_addr;
            o_dat  = i_m1_dat;
        end
    end

    // A late ack in the abort cycle still completes the transfer and suppresses the error.
    assign o_stb    = abort_q ? 4'd0 : own_stb;
    assign o_m0_ack = own0 && i_ack && (i_m0_stb != 4'd0);
    assign o_m1_ack = own1 && i_ack && (i_m1_stb != 4'd0);
    assign o_m0_err = own0 && abort_q && !i_ack;
    assign o_m1_err = own1 && abort_q && !i_ack;
    assign o_grant  = {own1, own0};
    assign o_m0_dat = i_dat;
    assign o_m1_dat = i_dat;

endmodule

// File: tb/tb_dcpu_bus_arbiter.sv
// Bench for dcpu_bus_arbiter: vector table, directed corner sequences and a random run against a reference model.
module tb_dcpu_bus_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m1_cyc, m0_we, m1_we, s_ack;
    logic [3:0]  m0_stb, m1_stb;
    logic [31:0] m0_addr, m1_addr, m0_wdat, m1_wdat, s_dat;
    logic        m0_ack, m1_ack, m0_err, m1_err, o_cyc, o_we;
    logic [3:0]  o_stb;
    logic [31:0] m0_rdat, m1_rdat, o_addr, o_dat;
    logic [1:0]  o_grant;

    int errors = 0;
    int checks = 0;

    dcpu_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_dat(m0_wdat),
        .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_dat(m0_rdat),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_dat(m1_wdat),
        .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_dat(m1_rdat),
        .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr), .o_dat(o_dat),
        .i_ack(s_ack), .i_dat(s_dat), .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, c0;
        logic [3:0] s0;
        logic       c1;
        logic [3:0] s1;
        logic       ack;
        logic [1:0] g;
        logic       a0, a1, oc;
    } vec_t;

    vec_t tbl[15];

    // reference model state
    int mown;
    bit mlast;
    int mrun;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 1'b0; m0_stb = 4'd0; m0_we = 1'b0; m0_addr = 32'h100; m0_wdat = 32'h0;
        m1_cyc = 1'b0; m1_stb = 4'd0; m1_we = 1'b0; m1_addr = 32'h200; m1_wdat = 32'h0;
        s_ack = 1'b0; s_dat = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        adv();
        adv();
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic r, input logic c0, input logic [3:0] s0, input logic c1,
                                input logic [3:0] s1, input logic ack, input logic [1:0] g,
                                input logic a0, input logic a1, input logic oc);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = ack;
        v.g = g; v.a0 = a0; v.a1 = a1; v.oc = oc;
        return v;
    endfunction

    task automatic model_check();
        logic       cy[2];
        logic [3:0] sb[2];
        logic       we[2];
        logic [31:0] ad[2];
        logic [31:0] wd[2];
        bit owned, ab;
        logic [1:0] eg;
        cy[0] = m0_cyc; cy[1] = m1_cyc; sb[0] = m0_stb; sb[1] = m1_stb;
        we[0] = m0_we;  we[1] = m1_we;  ad[0] = m0_addr; ad[1] = m1_addr;
        wd[0] = m0_wdat; wd[1] = m1_wdat;
        owned = (mown >= 0) && !rst;
        ab    = owned && (mrun == TO);
        eg    = !owned ? 2'b00 : (mown == 0 ? 2'b01 : 2'b10);
        chk("rnd_grant", 32'(o_grant), 32'(eg));
        chk("rnd_cyc",   32'(o_cyc),  owned ? 32'(cy[mown]) : 32'd0);
        chk("rnd_stb",   32'(o_stb),  (owned && !ab) ? 32'(sb[mown]) : 32'd0);
        chk("rnd_we",    32'(o_we),   owned ? 32'(we[mown]) : 32'd0);
        chk("rnd_addr",  o_addr,      owned ? ad[mown] : 32'd0);
        chk("rnd_wdat",  o_dat,       owned ? wd[mown] : 32'd0);
        chk("rnd_ack0",  32'(m0_ack), 32'(owned && mown == 0 && s_ack && sb[0] != 4'd0));
        chk("rnd_ack1",  32'(m1_ack), 32'(owned && mown == 1 && s_ack && sb[1] != 4'd0));
        chk("rnd_err0",  32'(m0_err), 32'(ab && mown == 0 && !s_ack));
        chk("rnd_err1",  32'(m1_err), 32'(ab && mown == 1 && !s_ack));
        chk("rnd_rdat",  m1_rdat,     s_dat);
    endtask

    task automatic model_update();
        logic       cy[2];
        logic [3:0] sb[2];
        bit owned, ab;
        cy[0] = m0_cyc; cy[1] = m1_cyc; sb[0] = m0_stb; sb[1] = m1_stb;
        if (rst) begin
            mown = -1; mlast = 1'b1; mrun = 0;
            return;
        end
        owned = (mown >= 0);
        ab    = owned && (mrun == TO);
        if (owned && !ab && sb[mown] != 4'd0 && !s_ack) mrun++;
        else mrun = 0;
        if (mown < 0) begin
            if (cy[0] && cy[1]) mown = mlast ? 0 : 1;
            else if (cy[0])     mown = 0;
            else if (cy[1])     mown = 1;
            if (mown >= 0) mlast = (mown == 1);
        end else if (!cy[mown]) begin
            mown = -1;
        end
    endtask

    initial begin
        int acks;
        rst = 1'b1;
        idle_inputs();
        adv();

        // rst, c0, s0, c1, s1, ack | grant, ack0, ack1, o_cyc
        tbl[0]  = mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
        tbl[7]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'h0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
            m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1; s_ack = tbl[i].ack;
            settle();
            chk($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(tbl[i].g));
            chk($sformatf("vec%0d_ack0", i),  32'(m0_ack),  32'(tbl[i].a0));
            chk($sformatf("vec%0d_ack1", i),  32'(m1_ack),  32'(tbl[i].a1));
            chk($sformatf("vec%0d_cyc", i),   32'(o_cyc),   32'(tbl[i].oc));
            if (tbl[i].rst) chk($sformatf("vec%0d_stb", i), 32'(o_stb), 32'd0);
            adv();
        end

        // single requester read with a two-cycle slave
        do_reset();
        m0_cyc = 1'b1; m0_stb = 4'hF; m0_addr = 32'h100;
        settle();
        chk("sr_grant_idle", 32'(o_grant), 32'd0);
        adv();
        settle();
        chk("sr_grant", 32'(o_grant), 32'd1);
        chk("sr_addr", o_addr, 32'h100);
        chk("sr_we", 32'(o_we), 32'd0);
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            s_ack = (k == 2);
            s_dat = (k == 2) ? 32'hDEADBEEF : 32'h0;
            settle();
            acks += int'(m0_ack);
            if (k == 2) chk("sr_rdat", m0_rdat, 32'hDEADBEEF);
            adv();
        end
        chk("sr_ack_count", 32'(acks), 32'd1);
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 4'h0;
        settle();
        chk("sr_release_grant", 32'(o_grant), 32'd1);
        adv();
        settle();
        chk("sr_idle_grant", 32'(o_grant), 32'd0);
        adv();

        // m1 holds the bus across three writes while m0 waits
        do_reset();
        m1_cyc = 1'b1;
        adv();
        m0_cyc = 1'b1; m0_stb = 4'hF; m0_addr = 32'h100;
        for (int w = 0; w < 3; w++) begin
            m1_stb = 4'hF; m1_we = 1'b1; m1_addr = 32'h10 + 32'(4 * w); s_ack = 1'b1;
            settle();
            chk("lk_grant", 32'(o_grant), 32'd2);
            chk("lk_addr", o_addr, 32'h10 + 32'(4 * w));
            chk("lk_we", 32'(o_we), 32'd1);
            chk("lk_ack1", 32'(m1_ack), 32'd1);
            chk("lk_ack0", 32'(m0_ack), 32'd0);
            adv();
            m1_stb = 4'h0;
            settle();
            chk("lk_gap_ack0", 32'(m0_ack), 32'd0);
            adv();
        end
        s_ack = 1'b0; m1_cyc = 1'b0;
        settle();
        chk("lk_release", 32'(o_grant), 32'd2);
        adv();
        settle();
        chk("lk_idle", 32'(o_grant), 32'd0);
        adv();
        settle();
        chk("lk_m0_grant", 32'(o_grant), 32'd1);
        chk("lk_m0_addr", o_addr, 32'h100);
        adv();

        // timeout abort, then an ack landing in the abort cycle
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            m0_cyc = 1'b1;
            adv();
            m0_stb = 4'hF;
            for (int k = 0; k <= TO; k++) begin
                s_ack = (pass == 1) && (k == TO);
                settle();
                if (pass == 0) begin
                    chk($sformatf("to_err_k%0d", k), 32'(m0_err), 32'(k == TO));
                    chk($sformatf("to_stb_k%0d", k), 32'(o_stb), (k == TO) ? 32'd0 : 32'hF);
                    chk("to_ack", 32'(m0_ack), 32'd0);
                end else if (k == TO) begin
                    chk("to_late_ack", 32'(m0_ack), 32'd1);
                    chk("to_late_err", 32'(m0_err), 32'd0);
                end else begin
                    chk("to_late_pre_err", 32'(m0_err), 32'd0);
                end
                adv();
            end
            s_ack = 1'b0;
            settle();
            chk("to_after_err", 32'(m0_err), 32'd0);
            chk("to_grant_kept", 32'(o_grant), 32'd1);
            adv();
        end

        // random traffic against the reference model
        do_reset();
        mown = -1; mlast = 1'b1; mrun = 0;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (m0_cyc) begin if ($urandom_range(0, 7) == 0) m0_cyc = 1'b0; end
            else if ($urandom_range(0, 3) == 0) m0_cyc = 1'b1;
            if (m1_cyc) begin if ($urandom_range(0, 7) == 0) m1_cyc = 1'b0; end
            else if ($urandom_range(0, 3) == 0) m1_cyc = 1'b1;
            if ($urandom_range(0, 7) == 0) m0_stb = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) m1_stb = 4'($urandom_range(0, 15));
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_wdat = $urandom; m1_wdat = $urandom;
            s_ack = ($urandom_range(0, 5) == 0);
            s_dat = $urandom;
            settle();
            model_check();
            model_update();
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
